// File: rtl/rc4_prga_checker_if.sv
// Bus bundle for the RC4 keystream/decrypt engine: start/status handshake,
// S-memory port, encrypted-ROM read port and decrypted-RAM write port.
interface rc4_prga_checker_if #(
  parameter int MSG_LEN = 32
);
  localparam int AW = $clog2(MSG_LEN);

  logic          start;
  logic          busy;
  logic          done;
  logic          key_ok;
  logic [7:0]    s_addr;
  logic [7:0]    s_wdata;
  logic          s_wen;
  logic [7:0]    s_q;
  logic [AW-1:0] enc_addr;
  logic [7:0]    enc_q;
  logic [AW-1:0] dec_addr;
  logic [7:0]    dec_wdata;
  logic          dec_wen;

  modport master (
    input  start, s_q, enc_q,
    output busy, done, key_ok, s_addr, s_wdata, s_wen,
           enc_addr, dec_addr, dec_wdata, dec_wen
  );

  modport slave (
    output start, s_q, enc_q,
    input  busy, done, key_ok, s_addr, s_wdata, s_wen,
           enc_addr, dec_addr, dec_wdata, dec_wen
  );
endinterface

// File: rtl/rc4_prga_checker.sv
// RC4 PRGA engine: swaps S, XORs keystream with ROM bytes, writes plaintext,
// and optionally aborts on the first byte outside {a..z, space}.
module rc4_prga_checker #(
  parameter int MSG_LEN  = 32,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  rc4_prga_checker_if.master  bus
);
  localparam int AW = $clog2(MSG_LEN);
  localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_DEC, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          fail_q, fail_d;
  logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
  logic [AW-1:0] k_q, k_d;

  logic          busy_q, busy_d, done_q, done_d, key_ok_q, key_ok_d;
  logic [7:0]    s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic          s_wen_q, s_wen_d, dec_wen_q, dec_wen_d;
  logic [AW-1:0] enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]    dec_wdata_q, dec_wdata_d;

  logic [7:0]    pt;
  logic          pt_ok;

  assign pt    = f_q ^ enc_q;
  assign pt_ok = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7A));

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    enc_d   = enc_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        i_d     = 8'd1;
        j_d     = 8'd0;
        k_d     = '0;
        fail_d  = 1'b0;
        state_d = RD_SI;
      end
      RD_SI:  state_d = WT_SI;
      WT_SI: begin
        si_d    = bus.s_q;
        j_d     = j_q + bus.s_q;
        state_d = RD_SJ;
      end
      RD_SJ:  state_d = WT_SJ;
      WT_SJ: begin
        sj_d    = bus.s_q;
        state_d = WR_SI;
      end
      WR_SI:  state_d = WR_SJ;
      WR_SJ:  state_d = RD_F;
      RD_F:   state_d = WT_F;
      WT_F: begin
        f_d     = bus.s_q;
        enc_d   = bus.enc_q;
        state_d = WR_DEC;
      end
      WR_DEC: state_d = NEXT;
      NEXT: begin
        i_d = i_q + 8'd1;
        k_d = k_q + AW'(1);
        if (CHECK_EN && !pt_ok) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          state_d = RD_SI;
        end
      end
      DONE:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  // while the matching state is current.
  always_comb begin
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    key_ok_d    = (state_d == DONE) && !fail_d;
    s_addr_d    = 8'd0;
    s_wdata_d   = 8'd0;
    s_wen_d     = 1'b0;
    enc_addr_d  = '0;
    dec_addr_d  = '0;
    dec_wdata_d = 8'd0;
    dec_wen_d   = 1'b0;
    case (state_d)
      RD_SI: s_addr_d = i_d;
      RD_SJ: s_addr_d = j_d;
      WR_SI: begin
        s_addr_d  = i_d;
        s_wdata_d = sj_d;
        s_wen_d   = 1'b1;
      end
      WR_SJ: begin
        s_addr_d  = j_d;
        s_wdata_d = si_d;
        s_wen_d   = 1'b1;
      end
      RD_F: begin
        s_addr_d   = si_d + sj_d;
        enc_addr_d = k_d;
      end
      WR_DEC: begin
        dec_addr_d  = k_d;
        dec_wdata_d = f_d ^ enc_d;
        dec_wen_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_ok_q    <= 1'b0;
      s_addr_q    <= 8'd0;
      s_wdata_q   <= 8'd0;
      s_wen_q     <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_wdata_q <= 8'd0;
      dec_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_ok_q    <= key_ok_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wen_q     <= s_wen_d;
      enc_addr_q  <= enc_addr_d;
      dec_addr_q  <= dec_addr_d;
      dec_wdata_q <= dec_wdata_d;
      dec_wen_q   <= dec_wen_d;
    end
  end

  // Datapath registers are always reloaded by IDLE before use, so no reset.
  always_ff @(posedge clk) begin
    i_q   <= i_d;
    j_q   <= j_d;
    k_q   <= k_d;
    si_q  <= si_d;
    sj_q  <= sj_d;
    f_q   <= f_d;
    enc_q <= enc_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_ok    = key_ok_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_wen     = s_wen_q;
  assign bus.enc_addr  = enc_addr_q;
  assign bus.dec_addr  = dec_addr_q;
  assign bus.dec_wdata = dec_wdata_q;
  assign bus.dec_wen   = dec_wen_q;
endmodule

// File: tb/tb_rc4_prga_checker.sv
// Bench for rc4_prga_checker: three configurations (3/check, 3/no-check,
// 300/no-check) with memory models and a plain-RC4 reference model.
module tb_rc4_prga_checker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_prga_checker_if #(.MSG_LEN(3))   ifa ();
  rc4_prga_checker_if #(.MSG_LEN(3))   ifb ();
  rc4_prga_checker_if #(.MSG_LEN(300)) ifc ();

  rc4_prga_checker #(.MSG_LEN(3),   .CHECK_EN(1'b1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  rc4_prga_checker #(.MSG_LEN(3),   .CHECK_EN(1'b0)) u_b (.clk(clk), .reset(reset), .bus(ifb));
  rc4_prga_checker #(.MSG_LEN(300), .CHECK_EN(1'b0)) u_c (.clk(clk), .reset(reset), .bus(ifc));

  logic [2:0] start_v, ld;
  logic [2:0] done_v, busy_v, keyok_v, swen_v;
  logic [7:0] saddr_v [3];
  assign ifa.start = start_v[0];
  assign ifb.start = start_v[1];
  assign ifc.start = start_v[2];
  assign done_v  = {ifc.done,   ifb.done,   ifa.done};
  assign busy_v  = {ifc.busy,   ifb.busy,   ifa.busy};
  assign keyok_v = {ifc.key_ok, ifb.key_ok, ifa.key_ok};
  assign swen_v  = {ifc.s_wen,  ifb.s_wen,  ifa.s_wen};
  assign saddr_v[0] = ifa.s_addr;
  assign saddr_v[1] = ifb.s_addr;
  assign saddr_v[2] = ifc.s_addr;

  logic [7:0] ldS  [256];
  logic [7:0] memS [3][256];
  logic [7:0] memE [3][300];
  logic [7:0] memD [3][300];
  logic       wr   [3][300];

  always @(posedge clk) begin
    if (ld[0]) begin
      for (int a = 0; a < 256; a++) memS[0][a] <= ldS[a];
      for (int a = 0; a < 300; a++) wr[0][a] <= 1'b0;
    end else begin
      ifa.s_q   <= memS[0][ifa.s_addr];
      ifa.enc_q <= memE[0][ifa.enc_addr];
      if (ifa.s_wen) memS[0][ifa.s_addr] <= ifa.s_wdata;
      if (ifa.dec_wen) begin
        memD[0][ifa.dec_addr] <= ifa.dec_wdata;
        wr[0][ifa.dec_addr]   <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (ld[1]) begin
      for (int a = 0; a < 256; a++) memS[1][a] <= ldS[a];
      for (int a = 0; a < 300; a++) wr[1][a] <= 1'b0;
    end else begin
      ifb.s_q   <= memS[1][ifb.s_addr];
      ifb.enc_q <= memE[1][ifb.enc_addr];
      if (ifb.s_wen) memS[1][ifb.s_addr] <= ifb.s_wdata;
      if (ifb.dec_wen) begin
        memD[1][ifb.dec_addr] <= ifb.dec_wdata;
        wr[1][ifb.dec_addr]   <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (ld[2]) begin
      for (int a = 0; a < 256; a++) memS[2][a] <= ldS[a];
      for (int a = 0; a < 300; a++) wr[2][a] <= 1'b0;
    end else begin
      ifc.s_q   <= memS[2][ifc.s_addr];
      ifc.enc_q <= memE[2][ifc.enc_addr];
      if (ifc.s_wen) memS[2][ifc.s_addr] <= ifc.s_wdata;
      if (ifc.dec_wen) begin
        memD[2][ifc.dec_addr] <= ifc.dec_wdata;
        wr[2][ifc.dec_addr]   <= 1'b1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: textbook RC4 PRGA over a copy of the loaded S.
  logic [7:0] mS [256];
  logic [7:0] mDec [300];
  int         mN;
  bit         mOk;

  task automatic ref_run(input int inst, input int len, input bit check);
    int i, j, p;
    logic [7:0] t;
    i = 0; j = 0; mN = 0; mOk = 1'b1;
    for (int a = 0; a < 256; a++) mS[a] = ldS[a];
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(mS[i])) % 256;
      t = mS[i]; mS[i] = mS[j]; mS[j] = t;
      p = int'(mS[(int'(mS[i]) + int'(mS[j])) % 256] ^ memE[inst][k]);
      mDec[k] = 8'(p);
      mN = k + 1;
      if (check && !(p == 32 || (p >= 97 && p <= 122))) begin
        mOk = 1'b0;
        break;
      end
    end
  endtask

  task automatic load(input int inst);
    @(negedge clk); ld[inst] = 1'b1;
    @(negedge clk); ld[inst] = 1'b0;
  endtask

  task automatic identity_s();
    for (int a = 0; a < 256; a++) ldS[a] = 8'(a);
  endtask

  task automatic random_s();
    logic [7:0] t;
    int r;
    identity_s();
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(0, a);
      t = ldS[a]; ldS[a] = ldS[r]; ldS[r] = t;
    end
  endtask

  // Enc bytes that decrypt to letters/spaces, except an illegal byte at bad_pos.
  task automatic make_enc(input int inst, input int len, input int bad_pos);
    int r;
    logic [7:0] ptb;
    for (int k = 0; k < len; k++) memE[inst][k] = 8'h00;
    ref_run(inst, len, 1'b0);
    for (int k = 0; k < len; k++) begin
      r = $urandom_range(0, 26);
      ptb = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      if (k == bad_pos) ptb = 8'($urandom_range(0, 31));
      memE[inst][k] = ptb ^ mDec[k];
    end
  endtask

  task automatic run_start(input int inst);
    @(negedge clk); start_v[inst] = 1'b1;
    @(posedge clk);
  endtask

  task automatic step(inout int cyc);
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic wait_done(input int inst, inout int cyc);
    while (!done_v[inst] && cyc < 3100) step(cyc);
  endtask

  task automatic drop_start(input int inst);
    @(negedge clk); start_v[inst] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_done", int'(done_v[inst]), 0);
  endtask

  task automatic check_run(input int inst, input int len, input int cyc);
    int bad;
    chk("cycles", cyc, 10 * mN);
    chk("done", int'(done_v[inst]), 1);
    chk("key_ok", int'(keyok_v[inst]), int'(mOk));
    for (int k = 0; k < len; k++) begin
      if (k < mN) begin
        chk($sformatf("dec%0d", k), int'(memD[inst][k]), int'(mDec[k]));
        chk($sformatf("wr%0d", k), int'(wr[inst][k]), 1);
      end else begin
        chk($sformatf("nowr%0d", k), int'(wr[inst][k]), 0);
      end
    end
    bad = 0;
    for (int a = 0; a < 256; a++) if (memS[inst][a] !== mS[a]) bad++;
    chk("s_final_mismatches", bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    start_v = '0;
    ld      = '0;
    reset   = 1'b0;
    for (int n = 0; n < 3; n++)
      for (int a = 0; a < 300; a++) memE[n][a] = 8'h00;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",   int'(busy_v[0]),  0);
    chk("rst_done",   int'(done_v[0]),  0);
    chk("rst_key_ok", int'(keyok_v[0]), 0);
    chk("rst_s_wen",  int'(swen_v[0]),  0);
    chk("rst_dec_wen", int'(ifa.dec_wen), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy_v[0]), 0);

    // Identity S, enc 63/64/66 decrypts to "aaa"
    identity_s(); load(0);
    memE[0][0] = 8'h63; memE[0][1] = 8'h64; memE[0][2] = 8'h66;
    ref_run(0, 3, 1'b1);
    run_start(0); cyc = 0; wait_done(0, cyc);
    check_run(0, 3, cyc);
    chk("kat_cycles", cyc, 30);
    chk("kat_key_ok", int'(keyok_v[0]), 1);
    for (int k = 0; k < 3; k++) chk($sformatf("kat_dec%0d", k), int'(memD[0][k]), 8'h61);
    chk("kat_s2", int'(memS[0][2]), 3);
    chk("kat_s3", int'(memS[0][3]), 5);
    chk("kat_s5", int'(memS[0][5]), 2);
    for (int n = 0; n < 5; n++) begin
      step(cyc);
      chk("hold_done", int'(done_v[0]), 1);
      chk("hold_busy", int'(busy_v[0]), 0);
    end
    drop_start(0);
    chk("idle_busy", int'(busy_v[0]), 0);

    // Early abort on byte 1
    identity_s(); load(0);
    memE[0][0] = 8'h63; memE[0][1] = 8'h00; memE[0][2] = 8'h66;
    ref_run(0, 3, 1'b1);
    run_start(0); cyc = 0; wait_done(0, cyc);
    check_run(0, 3, cyc);
    chk("abort_cycles", cyc, 20);
    chk("abort_key_ok", int'(keyok_v[0]), 0);
    chk("abort_dec1", int'(memD[0][1]), 8'h05);
    chk("abort_nowr2", int'(wr[0][2]), 0);
    drop_start(0);

    // Fresh run after a failure: state cleared, i=1 and j=0
    random_s(); load(0);
    make_enc(0, 3, -1);
    ref_run(0, 3, 1'b1);
    run_start(0); cyc = 0;
    @(negedge clk);
    chk("fresh_s_addr_i", int'(saddr_v[0]), 1);
    chk("fresh_key_ok", int'(keyok_v[0]), 0);
    chk("fresh_busy", int'(busy_v[0]), 1);
    step(cyc); step(cyc);
    chk("fresh_s_addr_j", int'(saddr_v[0]), int'(ldS[1]));
    wait_done(0, cyc);
    check_run(0, 3, cyc);
    drop_start(0);

    // Randomised runs with a random abort position (3 = no abort)
    for (int it = 0; it < 6; it++) begin
      random_s(); load(0);
      make_enc(0, 3, $urandom_range(0, 3));
      ref_run(0, 3, 1'b1);
      run_start(0); cyc = 0; wait_done(0, cyc);
      check_run(0, 3, cyc);
      drop_start(0);
    end

    // Check disabled: illegal byte does not stop the run
    identity_s(); load(1);
    memE[1][0] = 8'h63; memE[1][1] = 8'h00; memE[1][2] = 8'h66;
    ref_run(1, 3, 1'b0);
    run_start(1); cyc = 0; wait_done(1, cyc);
    check_run(1, 3, cyc);
    chk("nochk_cycles", cyc, 30);
    chk("nochk_key_ok", int'(keyok_v[1]), 1);
    chk("nochk_dec1", int'(memD[1][1]), 8'h05);
    chk("nochk_dec2", int'(memD[1][2]), 8'h61);
    drop_start(1);

    // Asynchronous reset during the first S write
    identity_s(); load(0);
    run_start(0); cyc = 0;
    @(negedge clk);
    for (int n = 0; n < 4; n++) step(cyc);
    chk("pre_rst_s_wen", int'(swen_v[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_s_wen",    int'(swen_v[0]),     0);
    chk("arst_busy",     int'(busy_v[0]),     0);
    chk("arst_s_addr",   int'(saddr_v[0]),    0);
    chk("arst_enc_addr", int'(ifa.enc_addr),  0);
    chk("arst_dec_addr", int'(ifa.dec_addr),  0);
    start_v[0] = 1'b0;
    @(negedge clk); reset = 1'b0;
    step(cyc);
    chk("arst_idle_busy", int'(busy_v[0]), 0);
    chk("arst_idle_done", int'(done_v[0]), 0);

    // 300-byte message: i and j wrap, k reaches 299
    random_s(); load(2);
    for (int k = 0; k < 300; k++) memE[2][k] = 8'($urandom_range(0, 255));
    ref_run(2, 300, 1'b0);
    run_start(2); cyc = 0; wait_done(2, cyc);
    check_run(2, 300, cyc);
    chk("long_cycles", cyc, 3000);
    chk("long_wr299", int'(wr[2][299]), 1);
    chk("long_key_ok", int'(keyok_v[2]), 1);
    drop_start(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
